// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer on the CPU bus (CTRL/PRESET/COUNT window).
// Supports one-shot and auto-reload modes; IRQ is the masked expiry flag.
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic [1:0]  idx;
    logic        wr_ctrl, wr_preset;
    logic        auto_rl;
    logic        irq_set, irq_auto_clr;

    // Addr is a word address, so byte address bits [31:4] live in Addr[29:2].
    assign hit       = (Addr[29:2] == BASE[31:4]);
    assign idx       = Addr[1:0];
    assign wr_ctrl   = WE && hit && (idx == 2'd0);
    assign wr_preset = WE && hit && (idx == 2'd1);
    assign auto_rl   = (ctrl_q[2:1] == 2'b01);
    assign IRQ       = irq_q & ctrl_q[3];

    always_comb begin
        Dout = 32'h0;
        if (hit) begin
            case (idx)
                2'd0:    Dout = {28'h0, ctrl_q};
                2'd1:    Dout = preset_q;
                2'd2:    Dout = count_q;
                default: Dout = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        preset_d     = preset_q;
        count_d      = count_q;
        irq_d        = irq_q;
        irq_set      = 1'b0;
        irq_auto_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    irq_set = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (auto_rl) irq_auto_clr = 1'b1;
                else         ctrl_d[0]    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // One-shot acknowledge: a PRESET write or a CTRL write that re-arms EN.
        // Writing only IM leaves the flag so a pending expiry shows at once.
        if ((wr_preset || (wr_ctrl && Din[0])) && (state_q != S_INT)) irq_d = 1'b0;
        if (irq_auto_clr) irq_d = 1'b0;
        if (irq_set)      irq_d = 1'b1;

        // Bus writes override the FSM's EN clear in the same cycle.
        if (wr_ctrl)   ctrl_d   = Din[3:0];
        if (wr_preset) preset_d = Din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'h0;
            preset_q <= 32'h0;
            count_q  <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, edge presets,
// disable mid-count, address decode and interrupt masking.
module tb_timer_counter;

    localparam logic [29:0] A_CTRL = 30'h1FC0;
    localparam logic [29:0] A_PRE  = 30'h1FC1;
    localparam logic [29:0] A_CNT  = 30'h1FC2;
    localparam logic [29:0] A_RSV  = 30'h1FC3;
    localparam logic [29:0] A_IDLE = 30'h0000;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    timer_counter #(.BASE(32'h0000_7F00)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        WE   = 1'b1;
        Din  = d;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Addr = A_IDLE;
        Din  = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [29:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, Dout, exp);
        Addr = A_IDLE;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'h0, IRQ}, {31'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        Addr  = A_IDLE;
        WE    = 1'b0;
        Din   = 32'h0;
        #12;
        chk_reg("rst_ctrl", A_CTRL, 32'h0);
        chk_reg("rst_pre",  A_PRE,  32'h0);
        chk_irq("rst_irq",  1'b0);
        @(negedge clk);
        reset = 1'b1;

        // reset mid-run while IRQ is high
        wr(A_PRE, 32'd7);
        wr(A_CTRL, 32'h9);
        step(9);
        chk_irq("pre_rst_irq", 1'b1);
        #2 reset = 1'b0;
        #1 chk_irq("async_rst_irq", 1'b0);
        chk_reg("mid_rst_ctrl", A_CTRL, 32'h0);
        chk_reg("mid_rst_pre",  A_PRE,  32'h0);
        chk_reg("mid_rst_cnt",  A_CNT,  32'h0);
        @(negedge clk);
        reset = 1'b1;

        // one-shot, PRESET=5
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        step(2);
        chk_reg("os_cnt5", A_CNT, 32'd5);
        for (int k = 4; k >= 1; k--) begin
            step(1);
            chk_reg("os_cnt", A_CNT, k);
        end
        chk_irq("os_irq_early", 1'b0);
        step(1);
        chk_irq("os_irq_t7", 1'b1);
        chk_reg("os_cnt0", A_CNT, 32'd0);
        step(1);
        chk_reg("os_ctrl", A_CTRL, 32'h8);
        step(3);
        chk_irq("os_irq_hold", 1'b1);
        wr(A_PRE, 32'd0);
        chk_irq("os_irq_clr", 1'b0);

        // auto-reload, PRESET=3, period 6
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int r = 0; r < 4; r++) begin
            step(4);
            chk_irq("ar_before", 1'b0);
            step(1);
            chk_irq("ar_pulse", 1'b1);
            step(1);
            chk_irq("ar_after", 1'b0);
        end
        chk_reg("ar_ctrl_en", A_CTRL, 32'hB);
        wr(A_CTRL, 32'h0);
        step(2);
        chk_irq("ar_off", 1'b0);

        // edge presets 0 and 1
        for (int p = 0; p < 2; p++) begin
            wr(A_PRE, p);
            wr(A_CTRL, 32'h9);
            step(2);
            chk_irq("edge_early", 1'b0);
            step(1);
            chk_irq("edge_t3", 1'b1);
            step(2);
        end
        wr(A_PRE, 32'hFFFF_FFFF);
        chk_irq("edge_clr", 1'b0);

        // maximum preset, no wrap
        wr(A_CTRL, 32'h1);
        step(2);
        chk_reg("max_load", A_CNT, 32'hFFFF_FFFF);
        step(1);
        chk_reg("max_dec", A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h0);

        // disable mid-count, then re-enable
        wr(A_PRE, 32'd100);
        wr(A_CTRL, 32'h1);
        step(42);
        chk_reg("dis_cnt60", A_CNT, 32'd60);
        wr(A_CTRL, 32'h0);
        step(3);
        chk_reg("dis_frozen", A_CNT, 32'd59);
        chk_irq("dis_irq", 1'b0);
        wr(A_CTRL, 32'h1);
        step(2);
        chk_reg("reen_load", A_CNT, 32'd100);
        step(1);
        chk_reg("reen_dec", A_CNT, 32'd99);
        wr(A_CTRL, 32'h0);

        // decode: COUNT/reserved writes and out-of-window accesses ignored
        wr(A_CNT, 32'h0000_1234);
        wr(A_RSV, 32'h0000_5555);
        wr(30'h1FD1, 32'h0000_DEAD);
        wr(30'h1FD0, 32'h9);
        wr(30'h2000_1FC1, 32'h0000_BEEF);
        step(2);
        chk_reg("dec_ctrl", A_CTRL, 32'h0);
        chk_reg("dec_pre",  A_PRE,  32'd100);
        chk_reg("dec_cnt",  A_CNT,  32'd98);
        chk_reg("dec_rsv",  A_RSV,  32'h0);
        chk_reg("dec_out1", 30'h1FD1, 32'h0);
        chk_reg("dec_out2", 30'h2000_1FC1, 32'h0);

        // masked one-shot expiry, then unmask
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        step(6);
        chk_irq("mask_irq", 1'b0);
        chk_reg("mask_ctrl", A_CTRL, 32'h0);
        wr(A_CTRL, 32'h8);
        chk_irq("unmask_irq", 1'b1);
        wr(A_PRE, 32'd0);
        chk_irq("unmask_clr", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
